alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the datapath's combinational ALU. It adds registered results, a status-flag output, an iterative shift-add multiplier, and valid/ready flow control on both sides. It sits between the register-file read stage and write-back, so the control unit can stall on multi-cycle operations.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits (≥ 4)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept an operation this cycle
- op_a  input  WIDTH  first operand
- op_b  input  WIDTH  second operand
- alu_func  input  4  opcode
- out_valid  output  1  alu_out/flags hold a valid result
- out_ready  input  1  consumer accepts result this cycle
- alu_out  output  WIDTH  registered result
- flags  output  4  {N, Z, C, V}, registered with alu_out
- illegal  output  1  result came from an unknown opcode

## Operation
- Opcodes: MOV 4'b0001 (= op_b), ADD 4'b0010, SUB 4'b0100 (op_a − op_b), AND 4'b0110, OR 4'b1000, XOR 4'b1010, MUL 4'b1100 (low WIDTH bits of unsigned op_a × op_b). All other codes are illegal.
- Illegal opcode: alu_out = 0, illegal = 1, flags = {0,1,0,0}. Completes as a single-cycle op.
- Arithmetic is modulo 2^WIDTH.
- Flags:
  - N = alu_out[WIDTH-1]; Z = (alu_out == 0).
  - ADD: C = carry out; V = signed overflow (operand signs equal, result sign differs).
  - SUB: C = borrow (1 iff op_a < op_b unsigned); V = signed overflow (operand signs differ, result sign ≠ op_a sign).
  - MUL: C = 1 iff upper WIDTH bits of the full product are nonzero; V = 0.
  - MOV/AND/OR/XOR: C = V = 0.
- States:
  - IDLE, BUSY (MUL iterating).
  - The output register is a separate one-entry holding stage flagged by out_valid.
- Transfers:
  - Accept occurs when in_valid && in_ready.
  - Result handoff occurs when out_valid && out_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A result may be consumed and a new op accepted in the same cycle.
- Single-cycle op accepted: the result loads the output register at that edge; the state stays IDLE.
- MUL accepted:
  - Latch operands, clear accumulator and counter, go to BUSY.
  - Each BUSY cycle: if multiplier LSB is 1, add the multiplicand to the 2·WIDTH-bit accumulator; shift the multiplicand left and the multiplier right; increment the counter.
  - After WIDTH iterations, load the output register, set out_valid, return to IDLE.
- BUSY never stalls: the output register is guaranteed free, because MUL was only accepted when the output would be free.
- Output holding: while out_valid && !out_ready, alu_out, flags and illegal stay stable.
- Operand and opcode inputs are ignored when not accepted.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, out_valid = 0, alu_out = 0, flags = 4'b0000, illegal = 0, accumulator and counter = 0.
  - in_ready = 1 from the first cycle after release.
- Single-cycle op accepted at edge T: out_valid = 1 after T, giving 1-cycle latency. Back-to-back throughput is 1 op/cycle when out_ready = 1.
- MUL accepted at edge T: in_ready = 0 during cycles T..T+WIDTH−1; out_valid = 1 after edge T+WIDTH, giving WIDTH-cycle latency.
- out_valid deasserts at the handoff edge unless a new single-cycle result loads at the same edge. In that case it stays 1 with the new data.
- Reset asserted mid-MUL: the operation is abandoned immediately and all outputs return to reset values. No partial result is ever presented.
- in_valid held with in_ready = 0: no state change; the op is accepted on the first cycle in_ready = 1.

## Test plan
- ADD 0xFFFF + 0x0001, out_ready = 1 (WIDTH = 16) -> next cycle alu_out = 0x0000, flags N=0 Z=1 C=1 V=0.
- SUB 0x8000 − 0x0001 -> 0x7FFF, flags N=0 Z=0 C=0 V=1. Then SUB 0x0001 − 0x0002 -> 0xFFFF, N=1 C=1 V=0.
- MUL 0x0123 × 0x0100 -> in_ready low for 16 cycles; alu_out = 0x2300, C=1, V=0, out_valid 16 cycles after accept.
- Backpressure: XOR 0x00FF ^ 0x0F0F with out_ready = 0 for 5 cycles -> alu_out = 0x0FF0 stable, in_ready = 0. When out_ready rises together with in_valid carrying MOV 0x1234 -> 0x1234 appears the next cycle with no bubble.
- alu_func = 4'b1111, op_a = 0x5555 -> alu_out = 0, illegal = 1, Z = 1. A following legal op clears illegal.
- Assert rst_n low 7 cycles into a MUL -> out_valid = 0, alu_out = 0, state IDLE. A fresh MUL 3 × 5 after release yields 0x000F.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with a one-entry registered result stage and an iterative
// shift-add multiplier; single-cycle ops complete in one clock, MUL in WIDTH.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1100;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     alu_out_q, alu_out_d;
    logic [3:0]           flags_q, flags_d;
    logic                 illegal_q, illegal_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH:0]       sum, diff;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH-1:0]     res;
    logic                 res_c, res_v, res_ill;

    function automatic logic [1:0] nz_flags(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], ~|r};
    endfunction

    // Single-cycle result path, evaluated on the presented operands
    always_comb begin
        sum     = {1'b0, op_a} + {1'b0, op_b};
        diff    = {1'b0, op_a} - {1'b0, op_b};
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        case (alu_func)
            OP_MOV: res = op_b;
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: res = op_a & op_b;
            OP_OR:  res = op_a | op_b;
            OP_XOR: res = op_a ^ op_b;
            default: res_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && alu_func == OP_MUL) begin
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end else if (accept) begin
                    alu_out_d   = res;
                    flags_d     = {nz_flags(res), res_c, res_v};
                    illegal_d   = res_ill;
                    out_valid_d = 1'b1;
                end
            end
            S_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The final iteration's sum goes straight to the output stage,
                // which is known to be empty since MUL waited for it.
                if (cnt_q == CNT_LAST) begin
                    alu_out_d   = acc_sum[WIDTH-1:0];
                    flags_d     = {nz_flags(acc_sum[WIDTH-1:0]), |acc_sum[2*WIDTH-1:WIDTH], 1'b0};
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= 4'b0000;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH = 16): hand-computed results,
// flags, latency, backpressure and mid-operation reset.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  alu_func;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
    logic [3:0]  flags;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_func  (alu_func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge; in_ready must already be high.
    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        alu_func = f;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] val, input logic [3:0] flg,
                              input logic ill);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out"},   32'(alu_out),   32'(val));
        chk({tag, ".flags"}, 32'(flags),     32'(flg));
        chk({tag, ".ill"},   32'(illegal),   32'(ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        alu_func  = '0;
        repeat (3) step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.out",   32'(alu_out),   32'd0);
        chk("rst.flags", 32'(flags),     32'd0);
        chk("rst.ill",   32'(illegal),   32'd0);
        rst_n = 1'b1;
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops, back to back with out_ready high
        issue(4'b0010, 16'hFFFF, 16'h0001);
        chk_result("add_wrap", 16'h0000, 4'b0110, 1'b0);
        issue(4'b0100, 16'h8000, 16'h0001);
        chk_result("sub_ovf", 16'h7FFF, 4'b0001, 1'b0);
        issue(4'b0100, 16'h0001, 16'h0002);
        chk_result("sub_brw", 16'hFFFF, 4'b1010, 1'b0);
        issue(4'b0110, 16'hF0F0, 16'h0FF0);
        chk_result("and", 16'h00F0, 4'b0000, 1'b0);
        issue(4'b1000, 16'h8000, 16'h0001);
        chk_result("or", 16'h8001, 4'b1000, 1'b0);
        issue(4'b0010, 16'h7FFF, 16'h0001);
        chk_result("add_ovf", 16'h8000, 4'b1001, 1'b0);
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);

        // MUL 0x0123 * 0x0100 = 0x12300: in_ready low for 16 cycles
        issue(4'b1100, 16'h0123, 16'h0100);
        chk("mul.busy0", 32'(in_ready), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step();
            chk($sformatf("mul.busy%0d", i), 32'({in_ready, out_valid}), 32'd0);
        end
        step();
        chk_result("mul", 16'h2300, 4'b0010, 1'b0);
        chk("mul.in_ready", 32'(in_ready), 32'd1);
        step();

        // Backpressure: XOR held, a pending MOV waits, then same-edge handoff/accept
        out_ready = 1'b0;
        issue(4'b1010, 16'h00FF, 16'h0F0F);
        alu_func = 4'b0001;
        op_a     = 16'hAAAA;
        op_b     = 16'h1234;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_result($sformatf("bp%0d", i), 16'h0FF0, 4'b0000, 1'b0);
            chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk_result("bp_mov", 16'h1234, 4'b0000, 1'b0);

        // Illegal opcode, then a legal op clears the flag
        issue(4'b1111, 16'h5555, 16'h0000);
        chk_result("illegal", 16'h0000, 4'b0100, 1'b1);
        issue(4'b0010, 16'h0001, 16'h0002);
        chk_result("post_ill", 16'h0003, 4'b0000, 1'b0);
        step();

        // Reset 7 cycles into a MUL abandons it
        issue(4'b1100, 16'h0007, 16'h0009);
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(out_valid), 32'd0);
        chk("mrst.out",   32'(alu_out),   32'd0);
        chk("mrst.flags", 32'(flags),     32'd0);
        step();
        step();
        rst_n = 1'b1;
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 20; i++) step();
        chk("mrst.no_result", 32'(out_valid), 32'd0);

        issue(4'b1100, 16'h0003, 16'h0005);
        for (int i = 1; i < 16; i++) step();
        chk("mul35.early", 32'(out_valid), 32'd0);
        step();
        chk_result("mul35", 16'h000F, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
